// File: rtl/apb_mem_pkg.sv
// Shared types and width helpers for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle for the memory slave, plus the write-protect sideband.
interface apb_mem_slave_if
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                        psel;
  logic                        penable;
  logic                        pwrite;
  logic [ADDR_W-1:0]           paddr;
  logic [DATA_W-1:0]           pwdata;
  logic [strb_w(DATA_W)-1:0]   pstrb;
  logic                        wp;
  logic [DATA_W-1:0]           prdata;
  logic                        pready;
  logic                        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, wp,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, wp,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_array.sv
// Word storage with per-byte-lane writes, registered read port and
// asynchronous clear of the whole array.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [strb_w(DATA_W)-1:0] wr_strb,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [DATA_W-1:0]         rd_data
);
  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage: cleared on reset, lane-masked writes otherwise.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_r[w] <= '0;
      end
    end else begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register: loads only when asked, otherwise returns to zero.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end else begin
      rd_data_r <= '0;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: transfer FSM, wait-state counter, address decode and
// error reporting around an apb_mem_array.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic            pclk,
  input  logic            prst,
  apb_mem_slave_if.slave  bus
);
  localparam int STRB_W = strb_w(DATA_W);
  localparam int OFF_W  = off_w(DATA_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        WS       = 4'(WAIT_STATES);

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic              write_r;
  logic              err_r;
  logic              pready_r;
  logic              pslverr_r;

  logic [ADDR_W-1:0] word_s;
  logic              setup_s;
  logic              err_s;
  logic              rd_en_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              wr_en_s;
  logic [STRB_W-1:0] wr_strb_s;
  logic [DATA_W-1:0] rd_data_s;

  assign word_s    = bus.paddr >> OFF_W;
  assign setup_s   = bus.psel & ~bus.penable;
  assign err_s     = (|(bus.paddr & OFF_MASK)) | (word_s >= DEPTH_A) | (bus.pwrite & bus.wp);
  assign wr_en_s   = (state_r == RESP) & bus.psel & bus.penable & bus.pwrite & write_r & ~err_r;
  assign wr_strb_s = wr_en_s ? bus.pstrb : '0;

  // Array read is requested on the edge that enters RESP for a clean read.
  always_comb begin
    rd_en_s  = 1'b0;
    rd_idx_s = idx_r;
    case (state_r)
      IDLE: begin
        if (setup_s && (WS == 4'd0)) begin
          rd_en_s  = ~bus.pwrite & ~err_s;
          rd_idx_s = word_s[IDX_W-1:0];
        end else begin
          rd_en_s  = 1'b0;
        end
      end
      WAIT: begin
        if (bus.psel && (cnt_r <= 4'd1)) begin
          rd_en_s = ~write_r & ~err_r;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: rd_en_s = 1'b0;
    endcase
  end

  // Transfer FSM with registered pready/pslverr.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      write_r   <= 1'b0;
      err_r     <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            idx_r   <= word_s[IDX_W-1:0];
            write_r <= bus.pwrite;
            err_r   <= err_s;
            if (WS == 4'd0) begin
              state_r   <= RESP;
              cnt_r     <= 4'd0;
              pready_r  <= 1'b1;
              pslverr_r <= err_s;
            end else begin
              state_r   <= WAIT;
              cnt_r     <= WS;
              pready_r  <= 1'b0;
              pslverr_r <= 1'b0;
            end
          end else begin
            state_r   <= IDLE;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
          end
        end
        WAIT: begin
          if (!bus.psel) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
          end else if (cnt_r <= 4'd1) begin
            state_r   <= RESP;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b1;
            pslverr_r <= err_r;
          end else begin
            cnt_r     <= cnt_r - 4'd1;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .pclk    (pclk),
    .prst    (prst),
    .wr_idx  (idx_r),
    .wr_strb (wr_strb_s),
    .wr_data (bus.pwdata),
    .rd_en   (rd_en_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  assign bus.prdata  = rd_data_s;
  assign bus.pready  = pready_r;
  assign bus.pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: one slave with zero wait states, one with three.
module tb_apb_mem_slave;

  logic        pclk;
  logic        prst;
  logic        dsel;
  logic        psel, penable, pwrite, wp;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  int          checks;
  int          failures;

  apb_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(12), .DATA_W(32)) bus3 ();

  assign bus0.psel    = psel & ~dsel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus0.wp      = wp;
  assign bus3.psel    = psel & dsel;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;
  assign bus3.wp      = wp;

  assign pready_m  = dsel ? bus3.pready  : bus0.pready;
  assign pslverr_m = dsel ? bus3.pslverr : bus0.pslverr;
  assign prdata_m  = dsel ? bus3.prdata  : bus0.prdata;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(32), .WAIT_STATES(0))
    dut0 (.pclk(pclk), .prst(prst), .bus(bus0));
  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(32), .WAIT_STATES(3))
    dut3 (.pclk(pclk), .prst(prst), .bus(bus3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wpv;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Full transfer starting with SETUP in the current cycle; returns in the cycle after RESP.
  task automatic xfer(input string name, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic wpv,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int exp_lat;
    exp_lat = dsel ? 4 : 1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; wp = wpv;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 1;
    while (!pready_m && lat < 40) begin
      @(posedge pclk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_prdata"}, prdata_m, exp_rdata);
    check({name, "_pslverr"}, {31'd0, pslverr_m}, {31'd0, exp_err});
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    check({name, "_pready_one_cycle"}, {31'd0, pready_m}, 32'd0);
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      check(name, {31'd0, pready_m}, 32'd0);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    dsel = 1'b0; prst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; wp = 1'b0;
    paddr = 12'h000; pwdata = 32'h0; pstrb = 4'h0;

    vecs[0]  = '{1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 12'h07C, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 32'h00000000, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 12'h010, 32'h11223344, 4'h5, 1'b0, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 12'h010, 32'h00000000, 4'h0, 1'b0, 32'hDE22BE44, 1'b0};
    vecs[6]  = '{1'b0, 12'h080, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 12'h013, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 12'h080, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 12'h010, 32'h00000000, 4'h0, 1'b1, 32'hDE22BE44, 1'b0};
    vecs[11] = '{1'b1, 12'h014, 32'hCAFEF00D, 4'h0, 1'b0, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 12'h014, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 12'h07C, 32'h12345678, 4'hF, 1'b0, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 12'h07C, 32'h00000000, 4'h0, 1'b0, 32'h12345678, 1'b0};
    vecs[15] = '{1'b0, 12'h000, 32'h00000000, 4'h0, 1'b0, 32'h00000000, 1'b0};
    vecs[16] = '{1'b1, 12'h011, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h00000000, 1'b1};
    vecs[17] = '{1'b0, 12'h010, 32'h00000000, 4'h0, 1'b0, 32'hDE22BE44, 1'b0};

    #3;
    check("reset_pready0",  {31'd0, bus0.pready},  32'd0);
    check("reset_pslverr0", {31'd0, bus0.pslverr}, 32'd0);
    check("reset_prdata0",  bus0.prdata, 32'd0);
    check("reset_pready3",  {31'd0, bus3.pready},  32'd0);
    @(posedge pclk); #1;
    prst = 1'b0;
    idle_check("idle_after_reset", 2);

    for (int i = 0; i < 18; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].strb, vecs[i].wpv, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // ACCESS-looking cycles without a SETUP must not start a transfer.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; wp = 1'b0;
    idle_check("no_setup_pready", 3);
    psel = 1'b0; penable = 1'b0;
    idle_check("no_setup_idle", 1);
    xfer("no_setup_read", 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h00000000, 1'b0);

    // Three-wait-state slave: normal write/read, error read.
    dsel = 1'b1;
    xfer("ws3_write", 1'b1, 12'h020, 32'hA5A55A5A, 4'hF, 1'b0, 32'h00000000, 1'b0);
    xfer("ws3_read",  1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 32'hA5A55A5A, 1'b0);
    xfer("ws3_oob",   1'b0, 12'h080, 32'h0, 4'h0, 1'b0, 32'h00000000, 1'b1);

    // Drop psel during WAIT of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h028;
    pwdata = 32'h55AA55AA; pstrb = 4'hF; wp = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    check("abort_wait_pready", {31'd0, pready_m}, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    idle_check("abort_after", 5);
    xfer("abort_readback", 1'b0, 12'h028, 32'h0, 4'h0, 1'b0, 32'h00000000, 1'b0);

    // Reset during WAIT of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h024;
    pwdata = 32'h12345678; pstrb = 4'hF; wp = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    #2;
    check("rst_wait_pready", {31'd0, pready_m}, 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    idle_check("rst_after", 4);
    xfer("rst_read_024", 1'b0, 12'h024, 32'h0, 4'h0, 1'b0, 32'h00000000, 1'b0);
    xfer("rst_read_020", 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 32'h00000000, 1'b0);

    dsel = 1'b0;
    for (int w = 0; w < 32; w++) begin
      xfer($sformatf("clear_word%0d", w), 1'b0, 12'(w * 4), 32'h0, 4'h0, 1'b0,
           32'h00000000, 1'b0);
    end
    xfer("post_rst_write", 1'b1, 12'h010, 32'h0BADF00D, 4'hF, 1'b0, 32'h00000000, 1'b0);
    xfer("post_rst_read",  1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
